// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add and one right shift per cycle.
// Product is built in place in R, with the multiplier consumed from its low half.
module shift_add_multiplier #(
  parameter int word_width = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [word_width-1:0]     A,
  input  logic [word_width-1:0]     B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*word_width-1:0]   R,
  output logic                      busy
);

  localparam int CW = $clog2(word_width);
  localparam logic [CW-1:0] LAST = CW'(word_width - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [word_width-1:0] m;
  logic [word_width:0]   sum;

  // Carry-out is kept as the top bit and shifted back into R.
  always_comb begin
    sum = {1'b0, R[2*word_width-1:word_width]};
    if (R[0]) begin
      sum = {1'b0, R[2*word_width-1:word_width]} + {1'b0, m};
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      m     <= '0;
      R     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            m   <= A;
            R   <= {{word_width{1'b0}}, B};
            cnt <= '0;
          end
        end
        RUN: begin
          R   <= {sum, R[word_width-1:1]};
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
